rf_write_scheduler: RTL and testbench

Sequencer for the DLX register-file write port. It arbitrates the writeback results of three producers onto the single RF write port: the ALU path, the load path from memory, and the multicycle multiplier. It sits between the producers and the write-back stage / register file. It performs valid/ready handshaking and round-robin arbitration, drops writes to R0, and raises a stall when any producer is left waiting.

---
 rtl/rf_write_scheduler.sv | 126 ++++++++++++
 tb/tb_rf_write_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_scheduler.sv
// Round-robin arbiter that funnels ALU, load and multiplier writebacks onto the
// single register-file write port, with a one-cycle registered write stage.
module rf_write_scheduler #(
    parameter int N  = 32,
    parameter int RA = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [RA-1:0] alu_addr,
    input  logic [N-1:0]  alu_data,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  logic [RA-1:0] mem_addr,
    input  logic [N-1:0]  mem_data,
    output logic          mem_ready,
    input  logic          mul_valid,
    input  logic [RA-1:0] mul_addr,
    input  logic [N-1:0]  mul_data,
    output logic          mul_ready,
    output logic          rf_we,
    output logic [RA-1:0] rf_waddr,
    output logic [N-1:0]  rf_wdata,
    output logic [1:0]    select_wb,
    output logic          stall
);

    // Handshake: a producer transfers in the cycle where its valid and ready are
    // both high; valid/addr/data are held by the producer until that cycle.
    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_MUL = 2'd2
    } src_e;

    src_e          last_q, last_d;
    src_e          gsrc;
    logic [2:0]    valid;
    logic [2:0]    grant;
    logic [RA-1:0] gaddr;
    logic [N-1:0]  gdata;

    logic          rf_we_q, rf_we_d;
    logic [RA-1:0] rf_waddr_q, rf_waddr_d;
    logic [N-1:0]  rf_wdata_q, rf_wdata_d;
    logic [1:0]    select_wb_q, select_wb_d;

    assign valid = {mul_valid, mem_valid, alu_valid};

    // Search starts at the source after the last winner; an illegal pointer
    // value falls into the default arm and behaves like MUL.
    always_comb begin
        grant = 3'b000;
        gsrc  = SRC_ALU;
        case (last_q)
            SRC_ALU: begin
                if (valid[1])      begin grant = 3'b010; gsrc = SRC_MEM; end
                else if (valid[2]) begin grant = 3'b100; gsrc = SRC_MUL; end
                else if (valid[0]) begin grant = 3'b001; gsrc = SRC_ALU; end
            end
            SRC_MEM: begin
                if (valid[2])      begin grant = 3'b100; gsrc = SRC_MUL; end
                else if (valid[0]) begin grant = 3'b001; gsrc = SRC_ALU; end
                else if (valid[1]) begin grant = 3'b010; gsrc = SRC_MEM; end
            end
            default: begin
                if (valid[0])      begin grant = 3'b001; gsrc = SRC_ALU; end
                else if (valid[1]) begin grant = 3'b010; gsrc = SRC_MEM; end
                else if (valid[2]) begin grant = 3'b100; gsrc = SRC_MUL; end
            end
        endcase
    end

    always_comb begin
        gaddr = alu_addr;
        gdata = alu_data;
        case (gsrc)
            SRC_MEM: begin gaddr = mem_addr; gdata = mem_data; end
            SRC_MUL: begin gaddr = mul_addr; gdata = mul_data; end
            default: begin gaddr = alu_addr; gdata = alu_data; end
        endcase
    end

    // R0 writes are acknowledged and recorded, but never enable the RF.
    always_comb begin
        last_d      = last_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        select_wb_d = select_wb_q;
        if (|grant) begin
            last_d      = gsrc;
            rf_we_d     = (gaddr != '0);
            rf_waddr_d  = gaddr;
            rf_wdata_d  = gdata;
            select_wb_d = gsrc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q      <= SRC_MUL;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            select_wb_q <= 2'd0;
        end else begin
            last_q      <= last_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            select_wb_q <= select_wb_d;
        end
    end

    assign alu_ready = grant[0];
    assign mem_ready = grant[1];
    assign mul_ready = grant[2];
    assign stall     = |(valid & ~grant);

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign select_wb = select_wb_q;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed and randomized checks of rf_write_scheduler against a round-robin
// reference model with an expected-write queue.
module tb_rf_write_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0, mem_valid = 1'b0, mul_valid = 1'b0;
    logic [4:0]  alu_addr = '0, mem_addr = '0, mul_addr = '0;
    logic [31:0] alu_data = '0, mem_data = '0, mul_data = '0;
    logic        alu_ready, mem_ready, mul_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  select_wb;
    logic        stall;

    rf_write_scheduler #(.N(32), .RA(5)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .mul_valid(mul_valid), .mul_addr(mul_addr), .mul_data(mul_data), .mul_ready(mul_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .select_wb(select_wb), .stall(stall)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: index of last winner (0 ALU, 1 MEM, 2 MUL) and the
    // held contents of the write register.
    int          m_last = 2;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic [1:0]  m_sel  = '0;
    int          wait_cnt[3];
    logic [39:0] exp_q[$];  // {sel, we, addr, data}

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [2:0] v);
        for (int k = 1; k <= 3; k++) begin
            int s;
            s = (m_last + k) % 3;
            if (v[s]) return s;
        end
        return -1;
    endfunction

    task automatic present(input int s, input logic [4:0] a, input logic [31:0] d);
        case (s)
            0: begin alu_valid = 1'b1; alu_addr = a; alu_data = d; end
            1: begin mem_valid = 1'b1; mem_addr = a; mem_data = d; end
            default: begin mul_valid = 1'b1; mul_addr = a; mul_data = d; end
        endcase
    endtask

    // One clock: check combinational handshake before the edge, then the
    // registered write stage just after it.
    task automatic step();
        logic [2:0]  v, rdy, gm;
        logic [4:0]  a;
        logic [31:0] d;
        logic [39:0] e;
        int g;
        @(negedge clk);
        v   = {mul_valid, mem_valid, alu_valid};
        rdy = {mul_ready, mem_ready, alu_ready};
        g   = model_grant(v);
        gm  = (g < 0) ? 3'b000 : 3'(1 << g);
        chk("alu_ready", 64'(rdy[0]), 64'(gm[0]));
        chk("mem_ready", 64'(rdy[1]), 64'(gm[1]));
        chk("mul_ready", 64'(rdy[2]), 64'(gm[2]));
        chk("stall", 64'(stall), 64'(|(v & ~gm)));
        for (int s = 0; s < 3; s++) begin
            if (v[s] && !rdy[s]) wait_cnt[s]++;
            else wait_cnt[s] = 0;
            if (v[s]) chk("starve_bound", 64'(wait_cnt[s] <= 2), 64'(1));
        end
        @(posedge clk);
        if (g >= 0) begin
            a = (g == 0) ? alu_addr : (g == 1) ? mem_addr : mul_addr;
            d = (g == 0) ? alu_data : (g == 1) ? mem_data : mul_data;
            m_last = g;
            m_addr = a;
            m_data = d;
            m_sel  = 2'(g);
            exp_q.push_back({m_sel, (a != 5'd0), m_addr, m_data});
        end else begin
            exp_q.push_back({m_sel, 1'b0, m_addr, m_data});
        end
        #1;
        e = exp_q.pop_front();
        chk("rf_we", 64'(rf_we), 64'(e[37]));
        chk("rf_waddr", 64'(rf_waddr), 64'(e[36:32]));
        chk("rf_wdata", 64'(rf_wdata), 64'(e[31:0]));
        chk("select_wb", 64'(select_wb), 64'(e[39:38]));
        if (g == 0) alu_valid = 1'b0;
        if (g == 1) mem_valid = 1'b0;
        if (g == 2) mul_valid = 1'b0;
    endtask

    task automatic do_reset(input bit at_once);
        if (at_once) #1;
        else begin
            @(posedge clk);
            #2;
        end
        rst = 1'b0;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        mul_valid = 1'b0;
        #1;
        chk("rst_rf_we", 64'(rf_we), 64'(0));
        chk("rst_rf_waddr", 64'(rf_waddr), 64'(0));
        chk("rst_rf_wdata", 64'(rf_wdata), 64'(0));
        chk("rst_select_wb", 64'(select_wb), 64'(0));
        chk("rst_readies", 64'({mul_ready, mem_ready, alu_ready}), 64'(0));
        chk("rst_stall", 64'(stall), 64'(0));
        m_last = 2;
        m_addr = '0;
        m_data = '0;
        m_sel  = '0;
        exp_q.delete();
        for (int s = 0; s < 3; s++) wait_cnt[s] = 0;
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        // Reset, then idle with no producers.
        do_reset(1'b1);
        step();
        step();

        // Single ALU write.
        present(0, 5'd5, 32'hDEADBEEF);
        step();
        chk("alu_single_addr", 64'(rf_waddr), 64'(5));

        // All three pending right after reset: ALU, MEM, MUL in order.
        do_reset(1'b0);
        present(0, 5'd1, 32'h11);
        present(1, 5'd2, 32'h22);
        present(2, 5'd3, 32'h33);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rr_order_sel", 64'(select_wb), 64'(k));
            chk("rr_order_addr", 64'(rf_waddr), 64'(k + 1));
        end

        // R0 load is acknowledged but never writes; then an ALU write to R7.
        present(1, 5'd0, 32'hFFFFFFFF);
        step();
        chk("r0_we", 64'(rf_we), 64'(0));
        chk("r0_sel", 64'(select_wb), 64'(1));
        present(0, 5'd7, 32'h0000_0777);
        present(2, 5'd8, 32'h0000_0888);
        step();
        chk("after_r0_sel", 64'(select_wb), 64'(2));
        step();
        chk("after_r0_alu", 64'(rf_waddr), 64'(7));

        // Fairness: MUL held, ALU and MEM re-presented every cycle.
        for (int c = 0; c < 12; c++) begin
            if (!mul_valid) present(2, 5'd9, $urandom);
            if (!alu_valid) present(0, 5'($urandom_range(1, 31)), $urandom);
            if (!mem_valid) present(1, 5'($urandom_range(1, 31)), $urandom);
            step();
        end
        for (int c = 0; c < 3; c++) step();

        // Async reset while a write is visible on the RF port.
        present(0, 5'd12, 32'hCAFEF00D);
        present(1, 5'd13, 32'h0BADF00D);
        step();
        step();
        chk("pre_async_we", 64'(rf_we), 64'(1));
        do_reset(1'b1);
        present(0, 5'd14, 32'h1414_1414);
        present(1, 5'd15, 32'h1515_1515);
        present(2, 5'd16, 32'h1616_1616);
        step();
        chk("post_rst_first_alu", 64'(select_wb), 64'(0));
        for (int c = 0; c < 2; c++) step();

        // Randomized traffic including R0 targets and idle cycles.
        for (int c = 0; c < 300; c++) begin
            for (int s = 0; s < 3; s++) begin
                logic vs;
                vs = (s == 0) ? alu_valid : (s == 1) ? mem_valid : mul_valid;
                if (!vs && $urandom_range(0, 1) == 1)
                    present(s, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                            $urandom);
            end
            step();
        end
        for (int c = 0; c < 4; c++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
